cpu_record_parser: RTL

- Sits directly downstream of cpu_checker and consumes the same char stream plus cpu_checker's format_type output.
- Extracts numeric fields from each "^time@pc: $grf <= data#" (register write) or "^time@pc: *addr <= data#" (memory write) line.
- Emits one record per line that cpu_checker accepted; lines it rejected are discarded.
- Records go to trace-compare logic over a valid/ready handshake.

---
 rtl/cpu_trace_pkg.sv | 27 ++
 rtl/cpu_record_parser_char_classify.sv | 24 ++
 rtl/cpu_record_parser.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared state, format and delimiter constants for the trace record parser
package cpu_trace_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_TIME = 4'd1;
  localparam logic [3:0] ST_PC   = 4'd2;
  localparam logic [3:0] ST_TGT  = 4'd3;
  localparam logic [3:0] ST_GRF  = 4'd4;
  localparam logic [3:0] ST_ADDR = 4'd5;
  localparam logic [3:0] ST_LT   = 4'd6;
  localparam logic [3:0] ST_DATA = 4'd7;
  localparam logic [3:0] ST_DONE = 4'd8;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

endpackage

// File: rtl/cpu_record_parser_char_classify.sv
// rtl/cpu_record_parser_char_classify.sv - ASCII decimal/hex digit classifier
module char_classify (
  input  logic [7:0] char_i,
  output logic       is_dec_o,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_dec_o = 1'b0;
    is_hex_o = 1'b0;
    nibble_o = 4'd0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      is_dec_o = 1'b1;
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0];
    end else if ((char_i >= 8'h61 && char_i <= 8'h66) || (char_i >= 8'h41 && char_i <= 8'h46)) begin
      // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_record_parser.sv
// rtl/cpu_record_parser.sv - extracts time/pc/target/data from cpu trace lines into records
// Optional macro RECORD_COUNT_EN enables the saturating rec_count counter.
module cpu_record_parser
  import cpu_trace_pkg::*;
#(
  parameter int TIME_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [1:0]        format_type,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [1:0]        rec_kind,
  output logic [TIME_W-1:0] rec_time,
  output logic [DATA_W-1:0] rec_pc,
  output logic [DATA_W-1:0] rec_target,
  output logic [DATA_W-1:0] rec_data,
  output logic              overflow,
  output logic [15:0]       rec_count
);

  logic [3:0]        state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [DATA_W-1:0] pc_q, pc_d, tgt_q, tgt_d, data_q, data_d;
  logic              is_dec, is_hex;
  logic [3:0]        nibble;

  char_classify u_classify (
    .char_i   (char),
    .is_dec_o (is_dec),
    .is_hex_o (is_hex),
    .nibble_o (nibble)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    data_d  = data_q;
    if (char == CH_CARET) begin
      state_d = ST_TIME;
      time_d  = '0;
      pc_d    = '0;
      tgt_d   = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        ST_TIME: if (char == CH_AT) state_d = ST_PC;
                 else if (is_dec) time_d = time_q * TIME_W'(10) + TIME_W'(nibble);
        ST_PC:   if (char == CH_COLON) state_d = ST_TGT;
                 else if (is_hex) pc_d = {pc_q[DATA_W-5:0], nibble};
        ST_TGT:  if (char == CH_DOLLAR) state_d = ST_GRF;
                 else if (char == CH_STAR) state_d = ST_ADDR;
        ST_GRF:  if (char == CH_LT) state_d = ST_LT;
                 else if (is_dec) tgt_d = tgt_q * DATA_W'(10) + DATA_W'(nibble);
        ST_ADDR: if (char == CH_LT) state_d = ST_LT;
                 else if (is_hex) tgt_d = {tgt_q[DATA_W-5:0], nibble};
        ST_LT:   if (char == CH_EQ) state_d = ST_DATA;
        ST_DATA: if (char == CH_HASH) state_d = ST_DONE;
                 else if (is_hex) data_d = {data_q[DATA_W-5:0], nibble};
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
    end
  end

  // format_type from cpu_checker is valid one cycle after '#', i.e. while in DONE
  logic capture, load;
  assign capture = (state_q == ST_DONE) && (format_type != FMT_NONE);
  assign load    = capture && (!rec_valid || rec_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_valid  <= 1'b0;
      rec_kind   <= 2'd0;
      rec_time   <= '0;
      rec_pc     <= '0;
      rec_target <= '0;
      rec_data   <= '0;
      overflow   <= 1'b0;
    end else if (load) begin
      rec_valid  <= 1'b1;
      rec_kind   <= format_type;
      rec_time   <= time_q;
      rec_pc     <= pc_q;
      rec_target <= tgt_q;
      rec_data   <= data_q;
    end else begin
      if (capture) overflow <= 1'b1;
      if (rec_valid && rec_ready) rec_valid <= 1'b0;
    end
  end

`ifdef RECORD_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= 16'd0;
    else if (load && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
  end
  assign rec_count = count_q;
`else
  assign rec_count = 16'd0;
`endif

endmodule
